// File: rtl/fu_cdb_arbiter.sv
// rtl/fu_cdb_arbiter.sv - rotating-priority arbiter from FU completion ports onto NUM_CDB CDB lanes
//
// Ports:
//   clock_i, reset_i   clock and asynchronous active-high reset
//   squash_i           flush: block all grants this cycle, clear lanes next edge
//   prepared_i         per-FU result ready (ALU low bits, then MULT, then LOAD)
//   req_prn_i/req_robn_i/req_data_i   per-FU result packets, packed by FU index
//   avail_o            per-FU "may advance" (granted or idle)
//   cdb_valid_o/cdb_prn_o/cdb_data_o/cdb_robn_o   registered CDB / ROB-completion lanes
//   ptr_o              current rotating priority pointer
module fu_cdb_arbiter #(
    parameter int NUM_ALU  = 3,
    parameter int NUM_MULT = 2,
    parameter int NUM_LOAD = 2,
    parameter int NUM_CDB  = 3,
    parameter int PRN_W    = 6,
    parameter int ROBN_W   = 5,
    parameter int N        = NUM_ALU + NUM_MULT + NUM_LOAD,
    parameter int PTR_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      squash_i,
    input  logic [N-1:0]              prepared_i,
    input  logic [N*PRN_W-1:0]        req_prn_i,
    input  logic [N*ROBN_W-1:0]       req_robn_i,
    input  logic [N*32-1:0]           req_data_i,
    output logic [N-1:0]              avail_o,
    output logic [NUM_CDB-1:0]        cdb_valid_o,
    output logic [NUM_CDB*PRN_W-1:0]  cdb_prn_o,
    output logic [NUM_CDB*32-1:0]     cdb_data_o,
    output logic [NUM_CDB*ROBN_W-1:0] cdb_robn_o,
    output logic [PTR_W-1:0]          ptr_o
);

    logic [N-1:0]              grant;
    logic [NUM_CDB-1:0]        cdb_valid_d, cdb_valid_q;
    logic [NUM_CDB*PRN_W-1:0]  cdb_prn_d, cdb_prn_q;
    logic [NUM_CDB*32-1:0]     cdb_data_d, cdb_data_q;
    logic [NUM_CDB*ROBN_W-1:0] cdb_robn_d, cdb_robn_q;
    logic [PTR_W-1:0]          ptr_d, ptr_q;
    int                        idx;
    int                        cnt;

    // Walk requesters in rotating order starting at ptr_q; the first NUM_CDB
    // prepared ones win, filling lanes in scan order. Squash suppresses every
    // grant so no FU consumes a result that would be flushed anyway.
    always_comb begin
        grant       = '0;
        cdb_valid_d = '0;
        cdb_prn_d   = '0;
        cdb_data_d  = '0;
        cdb_robn_d  = '0;
        ptr_d       = ptr_q;
        idx         = 0;
        cnt         = 0;
        for (int j = 0; j < N; j++) begin
            idx = (int'(ptr_q) + j) % N;
            if (!squash_i && prepared_i[idx] && (cnt < NUM_CDB)) begin
                grant[idx] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (cnt == k) begin
                        cdb_valid_d[k]                 = 1'b1;
                        cdb_prn_d[k*PRN_W +: PRN_W]    = req_prn_i[idx*PRN_W +: PRN_W];
                        cdb_data_d[k*32 +: 32]         = req_data_i[idx*32 +: 32];
                        cdb_robn_d[k*ROBN_W +: ROBN_W] = req_robn_i[idx*ROBN_W +: ROBN_W];
                    end
                end
                cnt   = cnt + 1;
                // Last grant in scan order decides where next cycle starts.
                ptr_d = PTR_W'((idx + 1) % N);
            end
        end
    end

    // Idle FUs are always free to advance; prepared ones only when granted.
    assign avail_o = grant | ~prepared_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cdb_valid_q <= '0;
            cdb_prn_q   <= '0;
            cdb_data_q  <= '0;
            cdb_robn_q  <= '0;
            ptr_q       <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_prn_q   <= cdb_prn_d;
            cdb_data_q  <= cdb_data_d;
            cdb_robn_q  <= cdb_robn_d;
            ptr_q       <= ptr_d;
        end
    end

    assign cdb_valid_o = cdb_valid_q;
    assign cdb_prn_o   = cdb_prn_q;
    assign cdb_data_o  = cdb_data_q;
    assign cdb_robn_o  = cdb_robn_q;
    assign ptr_o       = ptr_q;

endmodule
